mouse_position_tracker: RTL and testbench

- Consumes the raw 3-byte PS/2 packet registers (status, dX, dY) and the one-cycle packet-valid pulse produced by the mouse transceiver's master state machine.
- Accumulates signed movement into absolute, clamped X/Y screen coordinates for the 160x120 VGA frame.
- Presents button status and a sticky interrupt with acknowledge handshake to the downstream processor bus interface.

---
 rtl/mouse_position_tracker.sv | 165 ++++++++++++++++
 tb/tb_mouse_position_tracker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_position_tracker.sv
// PS/2 mouse packet consumer: turns raw packets into clamped absolute screen
// coordinates, button status, a sticky IRQ and a saturating drop counter.
module mouse_position_tracker #(
  parameter int MOUSE_LIMIT_X = 160,
  parameter int MOUSE_LIMIT_Y = 120,
  parameter bit INVERT_Y      = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MOUSE_STATUS_RAW,
  input  logic [7:0] MOUSE_DX_RAW,
  input  logic [7:0] MOUSE_DY_RAW,
  input  logic       PACKET_VALID,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [3:0] MOUSE_STATUS,
  output logic       IRQ,
  input  logic       IRQ_ACK,
  output logic [7:0] DROP_COUNT
);

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } packet_t;

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  localparam logic signed [9:0] X_MAX = 10'(MOUSE_LIMIT_X - 1);
  localparam logic signed [9:0] Y_MAX = 10'(MOUSE_LIMIT_Y - 1);

  state_t     state_q, state_d;
  packet_t    work_q, work_d;
  packet_t    pend_q, pend_d;
  logic       pend_full_q, pend_full_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [7:0] x_next_q, x_next_d, y_next_q, y_next_d;
  logic [2:0] btn_q, btn_d;
  logic       err_q, err_d;
  logic       irq_q, irq_d;
  logic [7:0] drop_q, drop_d;

  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic signed [9:0] sum_x, sum_y;
  packet_t           raw;

  // 9-bit two's-complement delta, zeroed when the axis overflowed.
  function automatic logic signed [9:0] axis_delta(input logic sign, input logic ovf,
                                                   input logic [7:0] mag);
    return ovf ? 10'sd0 : $signed({sign, sign, mag});
  endfunction

  function automatic logic [7:0] clamp_axis(input logic signed [9:0] sum,
                                            input logic signed [9:0] hi);
    if (sum[9])        return 8'd0;
    else if (sum > hi) return hi[7:0];
    else               return sum[7:0];
  endfunction

  assign raw   = '{status: MOUSE_STATUS_RAW, dx: MOUSE_DX_RAW, dy: MOUSE_DY_RAW};
  assign sum_x = $signed({2'b00, x_q}) + axis_delta(work_q.status[4], work_q.status[6], work_q.dx);
  assign sum_y = INVERT_Y ? $signed({2'b00, y_q}) - axis_delta(work_q.status[5], work_q.status[7], work_q.dy)
                          : $signed({2'b00, y_q}) + axis_delta(work_q.status[5], work_q.status[7], work_q.dy);

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    work_d      = work_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    x_d         = x_q;
    y_d         = y_q;
    x_next_d    = x_next_q;
    y_next_d    = y_next_q;
    btn_d       = btn_q;
    err_d       = err_q;
    irq_d       = IRQ_ACK ? 1'b0 : irq_q;
    drop_inc    = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          work_d      = pend_q;
          pend_full_d = 1'b0;
          state_d     = CALC_X;
        end else if (PACKET_VALID) begin
          work_d  = raw;
          state_d = CALC_X;
        end
      end
      CALC_X: begin
        x_next_d = clamp_axis(sum_x, X_MAX);
        state_d  = CALC_Y;
      end
      CALC_Y: begin
        y_next_d = clamp_axis(sum_y, Y_MAX);
        state_d  = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (work_q.status[3]) begin
          x_d   = x_next_q;
          y_d   = y_next_q;
          btn_d = work_q.status[2:0];
          irq_d = 1'b1;
        end else begin
          err_d    = 1'b1;
          drop_inc = drop_inc + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A packet not taken straight into the working registers parks in the
    // pending slot; overwriting an unconsumed one counts as a drop.
    if (PACKET_VALID && !(state_q == IDLE && !pend_full_q)) begin
      if (pend_full_q && state_q != IDLE) drop_inc = drop_inc + 2'd1;
      pend_d      = raw;
      pend_full_d = 1'b1;
    end

    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      x_q         <= 8'(MOUSE_LIMIT_X / 2);
      y_q         <= 8'(MOUSE_LIMIT_Y / 2);
      btn_q       <= 3'd0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      x_q         <= x_d;
      y_q         <= y_d;
      btn_q       <= btn_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      drop_q      <= drop_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only read after being loaded under valid/full control.
  always_ff @(posedge CLK) begin
    work_q   <= work_d;
    pend_q   <= pend_d;
    x_next_q <= x_next_d;
    y_next_q <= y_next_d;
  end

  assign MOUSE_X      = x_q;
  assign MOUSE_Y      = y_q;
  assign MOUSE_STATUS = {err_q, btn_q};
  assign IRQ          = irq_q;
  assign DROP_COUNT   = drop_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench for mouse_position_tracker: directed scenarios with literal
// expectations, then random traffic compared every cycle against a packet-level model.
module tb_mouse_position_tracker;

  logic       CLK;
  logic       RESET;
  logic [7:0] MOUSE_STATUS_RAW, MOUSE_DX_RAW, MOUSE_DY_RAW;
  logic       PACKET_VALID;
  logic [7:0] MOUSE_X, MOUSE_Y;
  logic [3:0] MOUSE_STATUS;
  logic       IRQ;
  logic       IRQ_ACK;
  logic [7:0] DROP_COUNT;

  mouse_position_tracker dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .MOUSE_STATUS_RAW (MOUSE_STATUS_RAW),
    .MOUSE_DX_RAW     (MOUSE_DX_RAW),
    .MOUSE_DY_RAW     (MOUSE_DY_RAW),
    .PACKET_VALID     (PACKET_VALID),
    .MOUSE_X          (MOUSE_X),
    .MOUSE_Y          (MOUSE_Y),
    .MOUSE_STATUS     (MOUSE_STATUS),
    .IRQ              (IRQ),
    .IRQ_ACK          (IRQ_ACK),
    .DROP_COUNT       (DROP_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned status;
    int unsigned dx;
    int unsigned dy;
  } pkt_t;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  int   m_x, m_y, m_btn, m_err, m_irq, m_drop;
  int   m_busy;        // 0 = waiting, 1..3 = cycles spent on the current packet
  pkt_t m_cur;
  pkt_t m_pend[$];

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int delta(input int unsigned mag, input bit sign, input bit ovf);
    if (ovf) return 0;
    return sign ? int'(mag) - 256 : int'(mag);
  endfunction

  always @(posedge CLK) begin
    pkt_t raw;
    int   drops;
    int   was;
    raw = '{MOUSE_STATUS_RAW, MOUSE_DX_RAW, MOUSE_DY_RAW};
    if (RESET) begin
      m_x = 80; m_y = 60; m_btn = 0; m_err = 0; m_irq = 0; m_drop = 0;
      m_busy = 0;
      m_pend.delete();
    end else begin
      drops = 0;
      was   = m_busy;
      if (was == 3 && m_cur.status[3]) begin
        m_x   = clamp(m_x + delta(m_cur.dx, m_cur.status[4], m_cur.status[6]), 0, 159);
        m_y   = clamp(m_y - delta(m_cur.dy, m_cur.status[5], m_cur.status[7]), 0, 119);
        m_btn = int'(m_cur.status & 7);
        m_irq = 1;
      end else begin
        if (was == 3) begin
          m_err = 1;
          drops++;
        end
        if (IRQ_ACK) m_irq = 0;
      end
      if (was == 0) begin
        if (m_pend.size() > 0) begin
          m_cur  = m_pend.pop_front();
          m_busy = 1;
          if (PACKET_VALID) m_pend.push_back(raw);
        end else if (PACKET_VALID) begin
          m_cur  = raw;
          m_busy = 1;
        end
      end else begin
        if (PACKET_VALID) begin
          if (m_pend.size() > 0) begin
            m_pend[0] = raw;
            drops++;
          end else begin
            m_pend.push_back(raw);
          end
        end
        m_busy = (was == 3) ? 0 : was + 1;
      end
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("x",      int'(MOUSE_X),      m_x);
      check("y",      int'(MOUSE_Y),      m_y);
      check("status", int'(MOUSE_STATUS), m_err * 8 + m_btn);
      check("irq",    int'(IRQ),          m_irq);
      check("drop",   int'(DROP_COUNT),   m_drop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    MOUSE_STATUS_RAW = s;
    MOUSE_DX_RAW     = x;
    MOUSE_DY_RAW     = y;
  endtask

  task automatic pulse(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    drive(s, x, y);
    PACKET_VALID = 1'b1;
    tick();
    PACKET_VALID = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int x, input int y, input int st,
                            input int irq, input int drop);
    check({tag, "_x"},      int'(MOUSE_X),      x);
    check({tag, "_y"},      int'(MOUSE_Y),      y);
    check({tag, "_status"}, int'(MOUSE_STATUS), st);
    check({tag, "_irq"},    int'(IRQ),          irq);
    check({tag, "_drop"},   int'(DROP_COUNT),   drop);
    check({tag, "_model_x"}, m_x, x);
    check({tag, "_model_y"}, m_y, y);
  endtask

  initial begin
    RESET = 1'b1;
    PACKET_VALID = 1'b0;
    IRQ_ACK = 1'b0;
    drive(8'h00, 8'h00, 8'h00);
    tick(3);
    RESET  = 1'b0;
    chk_en = 1'b1;
    expect_out("reset", 80, 60, 0, 0, 0);

    // Basic move; outputs appear on the edge ending COMMIT.
    pulse(8'h08, 8'h0A, 8'h05);
    tick(2);
    check("latency_irq_early", int'(IRQ), 0);
    tick();
    expect_out("move", 90, 55, 0, 1, 0);

    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    check("ack_clears", int'(IRQ), 0);

    pulse(8'h18, 8'h9C, 8'h00); tick(3);
    expect_out("clamp_lo", 0, 55, 0, 1, 0);
    pulse(8'h09, 8'hFF, 8'h00); tick(3);
    expect_out("clamp_hi", 159, 55, 1, 1, 0);

    pulse(8'h68, 8'h7F, 8'h10); tick(3);
    expect_out("xovf_yclamp", 159, 119, 0, 1, 0);

    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    pulse(8'h00, 8'h05, 8'h05); tick(3);
    expect_out("malformed", 159, 119, 8, 0, 1);

    // Three back-to-back packets: the middle one is overwritten in the pending slot.
    drive(8'h18, 8'hF6, 8'h00); PACKET_VALID = 1'b1; tick();
    drive(8'h18, 8'hFF, 8'h00); tick();
    drive(8'h18, 8'hEC, 8'h00); tick();
    PACKET_VALID = 1'b0;
    tick(8);
    expect_out("burst", 129, 119, 8, 1, 2);

    // Acknowledge landing on the commit edge loses to the new data.
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    check("ack_before_commit", int'(IRQ), 0);
    pulse(8'h08, 8'h00, 8'h00); tick(2);
    IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
    check("ack_vs_commit", int'(IRQ), 1);

    // Reset while the packet sits in CALC_Y.
    pulse(8'h08, 8'h0A, 8'h0A); tick();
    RESET = 1'b1; tick(); RESET = 1'b0;
    tick(5);
    expect_out("reset_mid", 80, 60, 0, 0, 0);

    // Continuous malformed traffic drives the drop counter into saturation.
    PACKET_VALID = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(8'(i & 8'hF7), 8'($urandom), 8'($urandom));
      tick();
    end
    PACKET_VALID = 1'b0;
    tick(10);
    check("drop_saturated", int'(DROP_COUNT), 255);

    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] s;
      s = 8'($urandom);
      if ($urandom_range(0, 7) != 0) s[3] = 1'b1;
      drive(s, 8'($urandom), 8'($urandom));
      PACKET_VALID = ($urandom_range(0, 2) == 0);
      IRQ_ACK      = ($urandom_range(0, 3) == 0);
      RESET        = ($urandom_range(0, 599) == 0);
      tick();
    end
    PACKET_VALID = 1'b0;
    IRQ_ACK = 1'b0;
    RESET = 1'b0;
    tick(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
